// File: rtl/tmds_pkg.sv
// TMDS constants shared by the encoder, decoder and receive-side deserializer.
package tmds_pkg;

    localparam int unsigned TMDS_W   = 10;
    localparam int unsigned OFFSET_W = 4;

    localparam logic [TMDS_W-1:0] TOKEN_0 = 10'h354;
    localparam logic [TMDS_W-1:0] TOKEN_1 = 10'h0AB;
    localparam logic [TMDS_W-1:0] TOKEN_2 = 10'h154;
    localparam logic [TMDS_W-1:0] TOKEN_3 = 10'h2AB;

    typedef enum logic {StSearch, StLocked} align_state_e;

    function automatic logic is_ctrl_token(input logic [TMDS_W-1:0] w);
        return (w == TOKEN_0) || (w == TOKEN_1) || (w == TOKEN_2) || (w == TOKEN_3);
    endfunction

endpackage

// File: rtl/tmds_word_align.sv
// Word-alignment FSM: hunts all ten bit offsets for runs of control tokens and
// holds lock until the token stream disappears for too long.
module tmds_word_align
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_RUN     = 8,
    parameter int unsigned SEARCH_WORDS = 64,
    parameter int unsigned LOSS_WORDS   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TMDS_W-1:0]   word,
    input  logic                data_vld,
    output logic [OFFSET_W-1:0] bit_offset,
    output logic                locked
);

    localparam int unsigned WORD_MAX = (SEARCH_WORDS > LOSS_WORDS) ? SEARCH_WORDS : LOSS_WORDS;
    localparam int unsigned RUN_W    = $clog2(LOCK_RUN + 1);
    localparam int unsigned WCNT_W   = $clog2(WORD_MAX + 1);

    localparam logic [RUN_W-1:0]    RUN_LIMIT    = RUN_W'(LOCK_RUN);
    localparam logic [WCNT_W-1:0]   SEARCH_LIMIT = WCNT_W'(SEARCH_WORDS);
    localparam logic [WCNT_W-1:0]   LOSS_LIMIT   = WCNT_W'(LOSS_WORDS);
    localparam logic [WCNT_W-1:0]   WCNT_SAT     = WCNT_W'(WORD_MAX);
    localparam logic [OFFSET_W-1:0] OFFSET_LAST  = OFFSET_W'(TMDS_W - 1);

    align_state_e      state;
    logic [RUN_W-1:0]  run_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic [RUN_W-1:0]  run_inc;
    logic [WCNT_W-1:0] word_inc;
    logic              tok;

    // Saturating increments so neither counter can ever wrap back to zero.
    always_comb begin
        tok      = is_ctrl_token(word);
        run_inc  = (run_cnt >= RUN_LIMIT) ? run_cnt : run_cnt + RUN_W'(1);
        word_inc = (word_cnt >= WCNT_SAT) ? word_cnt : word_cnt + WCNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StSearch;
            run_cnt    <= '0;
            word_cnt   <= '0;
            bit_offset <= '0;
            locked     <= 1'b0;
        end else if (data_vld) begin
            case (state)
                StSearch: begin
                    if (tok && (run_inc >= RUN_LIMIT)) begin
                        state    <= StLocked;
                        locked   <= 1'b1;
                        run_cnt  <= '0;
                        word_cnt <= '0;
                    end else if (word_inc >= SEARCH_LIMIT) begin
                        bit_offset <= (bit_offset == OFFSET_LAST) ? '0 :
                                      bit_offset + OFFSET_W'(1);
                        run_cnt    <= '0;
                        word_cnt   <= '0;
                    end else begin
                        run_cnt  <= tok ? run_inc : '0;
                        word_cnt <= word_inc;
                    end
                end
                StLocked: begin
                    if (tok) begin
                        word_cnt <= '0;
                    end else if (word_inc >= LOSS_LIMIT) begin
                        state    <= StSearch;
                        locked   <= 1'b0;
                        run_cnt  <= '0;
                        word_cnt <= '0;
                    end else begin
                        word_cnt <= word_inc;
                    end
                end
                default: state <= StSearch;
            endcase
        end
    end

endmodule

// File: rtl/ser_to_par.sv
// TMDS 10:1 deserializer: gathers DDR bit pairs into a 20-bit history and cuts
// an aligned 10-bit word out of it every fifth clk_5x cycle.
module ser_to_par
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_RUN     = 8,
    parameter int unsigned SEARCH_WORDS = 64,
    parameter int unsigned LOSS_WORDS   = 4096
) (
    input  logic                clk_5x,
    input  logic                rst,
    input  logic                bit_rise,
    input  logic                bit_fall,
    output logic [TMDS_W-1:0]   data_out,
    output logic                data_vld,
    output logic                is_token,
    output logic                locked,
    output logic [OFFSET_W-1:0] bit_offset
);

    localparam int unsigned SR_W       = 2 * TMDS_W;
    localparam logic [2:0]  PHASE_LAST = 3'd4;

    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_next;
    logic [TMDS_W-1:0] window;
    logic [2:0]        phase;

    // Newest bits enter at the top, so the oldest bit of the window lands in bit 0.
    always_comb begin
        sr_next = {bit_fall, bit_rise, sr[SR_W-1:2]};
        window  = sr_next[bit_offset +: TMDS_W];
    end

    always_ff @(posedge clk_5x or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            phase    <= '0;
            data_out <= '0;
            data_vld <= 1'b0;
            is_token <= 1'b0;
        end else begin
            sr       <= sr_next;
            data_vld <= (phase == PHASE_LAST);
            if (phase == PHASE_LAST) begin
                phase    <= '0;
                data_out <= window;
                is_token <= is_ctrl_token(window);
            end else begin
                phase <= phase + 3'd1;
            end
        end
    end

    tmds_word_align #(
        .LOCK_RUN     (LOCK_RUN),
        .SEARCH_WORDS (SEARCH_WORDS),
        .LOSS_WORDS   (LOSS_WORDS)
    ) u_align (
        .clk        (clk_5x),
        .rst        (rst),
        .word       (data_out),
        .data_vld   (data_vld),
        .bit_offset (bit_offset),
        .locked     (locked)
    );

endmodule
